// File: rtl/video_pkg.sv
// Shared 1080p60 raster constants, pixel width and stream-alignment state type.
package video_pkg;

  localparam int H_ACTIVE = 1920;
  localparam int H_FP     = 88;
  localparam int H_SYNC   = 44;
  localparam int H_BP     = 148;
  localparam int V_ACTIVE = 1080;
  localparam int V_FP     = 4;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 36;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int PIX_W    = 24;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/video_timing_counter.sv
// Free-running horizontal/vertical raster counters and the region flags derived
// from them (active area, raw sync windows, raster origin).
module video_timing_counter #(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE,
  parameter int H_FP     = video_pkg::H_FP,
  parameter int H_SYNC   = video_pkg::H_SYNC,
  parameter int H_BP     = video_pkg::H_BP,
  parameter int V_ACTIVE = video_pkg::V_ACTIVE,
  parameter int V_FP     = video_pkg::V_FP,
  parameter int V_SYNC   = video_pkg::V_SYNC,
  parameter int V_BP     = video_pkg::V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic origin
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;

  // Wrap by explicit compare so non-power-of-two totals work.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == HW'(H_TOT - 1)) begin
      h_count <= '0;
      v_count <= (v_count == VW'(V_TOT - 1)) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  assign active    = (h_count < HW'(H_ACTIVE)) && (v_count < VW'(V_ACTIVE));
  assign hsync_raw = (h_count >= HW'(H_ACTIVE + H_FP)) &&
                     (h_count <  HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_raw = (v_count >= VW'(V_ACTIVE + V_FP)) &&
                     (v_count <  VW'(V_ACTIVE + V_FP + V_SYNC));
  assign origin    = (h_count == '0) && (v_count == '0);

endmodule

// File: rtl/video_timing_out.sv
// AXI-Stream pixel flow to raster video: aligns the stream's start-of-frame beat
// to raster origin and falls back to search on underflow or misalignment.
module video_timing_out #(
  parameter int   H_ACTIVE  = video_pkg::H_ACTIVE,
  parameter int   H_FP      = video_pkg::H_FP,
  parameter int   H_SYNC    = video_pkg::H_SYNC,
  parameter int   H_BP      = video_pkg::H_BP,
  parameter int   V_ACTIVE  = video_pkg::V_ACTIVE,
  parameter int   V_FP      = video_pkg::V_FP,
  parameter int   V_SYNC    = video_pkg::V_SYNC,
  parameter int   V_BP      = video_pkg::V_BP,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_axis_tvalid,
  output logic                      in_axis_tready,
  input  logic [video_pkg::PIX_W-1:0] in_axis_tdata,
  input  logic                      in_axis_tuser,
  output logic                      vid_de,
  output logic                      vid_hsync,
  output logic                      vid_vsync,
  output logic [video_pkg::PIX_W-1:0] vid_data,
  output logic                      locked,
  output logic                      underflow,
  input  logic                      underflow_clr
);

  import video_pkg::*;

  logic   active, hsync_raw, vsync_raw, origin;
  state_t state, state_next;
  logic   resync_cond, underflow_set, show;

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .origin    (origin)
  );

  // Handshake and next-state decision from the current raster position.
  always_comb begin
    state_next     = state;
    in_axis_tready = 1'b0;
    underflow_set  = 1'b0;
    resync_cond    = in_axis_tvalid &&
                     ((in_axis_tuser && active && !origin) || (!in_axis_tuser && origin));
    case (state)
      SEARCH: begin
        // Non-SOF beats are drained; the SOF beat is held until origin.
        in_axis_tready = !in_axis_tuser || origin;
        if (in_axis_tvalid && in_axis_tuser && origin) begin
          state_next = LOCKED;
        end else begin
          state_next = SEARCH;
        end
      end
      LOCKED: begin
        in_axis_tready = active && !resync_cond;
        if (resync_cond) begin
          state_next = SEARCH;
        end else if (active && !in_axis_tvalid) begin
          state_next    = SEARCH;
          underflow_set = 1'b1;
        end else begin
          state_next = LOCKED;
        end
      end
      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  // Only the aligning SOF beat or beats taken while locked reach the screen.
  assign show = in_axis_tvalid && in_axis_tready && active &&
                ((state == LOCKED) || (in_axis_tuser && origin));

  // State, sticky status and the registered video outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      vid_de    <= 1'b0;
      vid_hsync <= !HSYNC_POL;
      vid_vsync <= !VSYNC_POL;
      vid_data  <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      vid_de    <= active;
      vid_hsync <= hsync_raw ? HSYNC_POL : !HSYNC_POL;
      vid_vsync <= vsync_raw ? VSYNC_POL : !VSYNC_POL;
      vid_data  <= show ? in_axis_tdata : '0;
      underflow <= underflow_set | (underflow & !underflow_clr);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_video_timing_out.sv
// Directed bench on a shrunken raster: a reference model pushes expected outputs
// per cycle into a scoreboard that is popped one clock later against the DUT.
module tb_video_timing_out;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME_PIX = HA * VA;
  localparam int FRAME_CLK = HT * VT;

  logic        clk = 1'b0;
  logic        reset, in_axis_tvalid, in_axis_tuser, underflow_clr;
  logic [23:0] in_axis_tdata;
  logic        in_axis_tready, vid_de, vid_hsync, vid_vsync, locked, underflow;
  logic [23:0] vid_data;
  logic        tready_n, vid_de_n, vid_hsync_n, vid_vsync_n, locked_n, underflow_n;
  logic [23:0] vid_data_n;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] data;
    logic        lk;
    logic        uf;
  } exp_t;

  exp_t sb[$];

  int passed = 0, total = 0;
  int m_h = 0, m_v = 0;
  logic m_locked = 1'b0, m_uf = 1'b0;
  int src_k = 0, junk = 0;
  logic [15:0] seq = 16'd0;
  int dut_acc = 0, de_cnt = 0;

  always #5 clk = ~clk;

  video_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_axis_tvalid(in_axis_tvalid), .in_axis_tready(in_axis_tready),
    .in_axis_tdata(in_axis_tdata), .in_axis_tuser(in_axis_tuser),
    .vid_de(vid_de), .vid_hsync(vid_hsync), .vid_vsync(vid_vsync),
    .vid_data(vid_data), .locked(locked), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  video_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut_neg (
    .clk(clk), .reset(reset),
    .in_axis_tvalid(in_axis_tvalid), .in_axis_tready(tready_n),
    .in_axis_tdata(in_axis_tdata), .in_axis_tuser(in_axis_tuser),
    .vid_de(vid_de_n), .vid_hsync(vid_hsync_n), .vid_vsync(vid_vsync_n),
    .vid_data(vid_data_n), .locked(locked_n), .underflow(underflow_n),
    .underflow_clr(underflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic drive_src();
    in_axis_tuser = (junk == 0) && (src_k == 0);
    in_axis_tdata = {seq[7:0] ^ 8'h5A, seq};
  endtask

  task automatic advance_src();
    seq = seq + 16'd1;
    if (junk > 0) junk--;
    else src_k = (src_k + 1) % FRAME_PIX;
  endtask

  task automatic step();
    exp_t e;
    logic act, org, hs, vs, rs, rdy, acc, uf_set, nxt;
    @(negedge clk);
    e = '0;
    if (reset) begin
      m_h = 0; m_v = 0; m_locked = 1'b0; m_uf = 1'b0;
    end else begin
      act = (m_h < HA) && (m_v < VA);
      org = (m_h == 0) && (m_v == 0);
      hs  = (m_h >= HA + HFP) && (m_h < HA + HFP + HS);
      vs  = (m_v >= VA + VFP) && (m_v < VA + VFP + VS);
      rs  = in_axis_tvalid && ((in_axis_tuser && act && !org) || (!in_axis_tuser && org));
      rdy = m_locked ? (act && !rs) : (!in_axis_tuser || org);
      check("tready", 32'(in_axis_tready), 32'(rdy));
      if (in_axis_tvalid && in_axis_tready) dut_acc++;
      acc    = in_axis_tvalid && rdy;
      uf_set = 1'b0;
      nxt    = m_locked;
      if (!m_locked) begin
        if (in_axis_tvalid && in_axis_tuser && org) nxt = 1'b1;
      end else if (rs) begin
        nxt = 1'b0;
      end else if (act && !in_axis_tvalid) begin
        nxt = 1'b0; uf_set = 1'b1;
      end
      e.de   = act;
      e.hs   = hs;
      e.vs   = vs;
      e.data = (acc && act && (m_locked || (in_axis_tuser && org))) ? in_axis_tdata : 24'h0;
      m_uf   = uf_set ? 1'b1 : (underflow_clr ? 1'b0 : m_uf);
      m_locked = nxt;
      if (acc) advance_src();
      if (m_h == HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    e.lk = m_locked;
    e.uf = m_uf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (vid_de) de_cnt++;
    check("vid_de", 32'(vid_de), 32'(e.de));
    check("vid_hsync", 32'(vid_hsync), 32'(e.hs));
    check("vid_vsync", 32'(vid_vsync), 32'(e.vs));
    check("vid_data", 32'(vid_data), 32'(e.data));
    check("locked", 32'(locked), 32'(e.lk));
    check("underflow", 32'(underflow), 32'(e.uf));
    check("hsync_pol0", 32'(vid_hsync_n), 32'(!e.hs));
    check("vsync_pol0", 32'(vid_vsync_n), 32'(!e.vs));
    drive_src();
  endtask

  initial begin
    reset = 1'b1; in_axis_tvalid = 1'b1; underflow_clr = 1'b0;
    drive_src();
    repeat (3) step();

    // Continuous supply from reset: lock at first origin, two full frames.
    reset = 1'b0;
    dut_acc = 0; de_cnt = 0;
    step();
    check("first_pixel", 32'(vid_data), 32'h005A_0000);
    check("locked_after_sof", 32'(locked), 32'd1);
    repeat (FRAME_CLK - 1) step();
    check("beats_frame1", 32'(dut_acc), 32'(FRAME_PIX));
    check("de_frame1", 32'(de_cnt), 32'(FRAME_PIX));
    dut_acc = 0; de_cnt = 0;
    repeat (FRAME_CLK) step();
    check("beats_frame2", 32'(dut_acc), 32'(FRAME_PIX));
    check("de_frame2", 32'(de_cnt), 32'(FRAME_PIX));
    check("no_underflow", 32'(underflow), 32'd0);

    // Mid-frame reset, then 100 junk beats ahead of a held SOF beat.
    repeat (7) step();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    junk = 100; src_k = 0;
    drive_src();
    dut_acc = 0;
    repeat (100) step();
    check("junk_dropped", 32'(dut_acc), 32'd100);
    repeat (FRAME_CLK - 100) step();
    check("sof_held", 32'(dut_acc), 32'd100);
    step();
    check("relock_after_junk", 32'(locked), 32'd1);

    // Underflow at (5,2) with clear in the same cycle; set must win.
    for (int i = 0; i < 2 * FRAME_CLK && !(m_h == 5 && m_v == 2 && m_locked); i++) step();
    check("reach_5_2", 32'(m_h == 5 && m_v == 2), 32'd1);
    in_axis_tvalid = 1'b0; underflow_clr = 1'b1;
    step();
    in_axis_tvalid = 1'b1; underflow_clr = 1'b0;
    check("uf_set_beats_clr", 32'(underflow), 32'd1);
    check("unlocked_on_uf", 32'(locked), 32'd0);
    for (int i = 0; i < 2 * FRAME_CLK && !m_locked; i++) step();
    check("relock_after_uf", 32'(locked), 32'd1);
    step();
    underflow_clr = 1'b1;
    step();
    underflow_clr = 1'b0;
    check("uf_cleared", 32'(underflow), 32'd0);

    // Early SOF beat at (1,3) while locked forces resync.
    for (int i = 0; i < 2 * FRAME_CLK && !(m_h == 1 && m_v == 3 && m_locked); i++) step();
    check("reach_1_3", 32'(m_h == 1 && m_v == 3), 32'd1);
    src_k = 0;
    drive_src();
    step();
    check("unlocked_on_sof", 32'(locked), 32'd0);
    for (int i = 0; i < 2 * FRAME_CLK && !m_locked; i++) step();
    check("relock_after_sof", 32'(locked), 32'd1);
    repeat (FRAME_CLK) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
